// File: rtl/adc_init_pkg.sv
// Shared definitions for the ADC bring-up sequencer: state codes, field widths
// and the triplicated sequencer context.
package adc_init_pkg;

    localparam int SER_W = 16;
    localparam int IDX_W = 3;
    localparam int DLY_W = 16;
    localparam int HC_W  = 5;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HARDRST = 3'd1;
    localparam logic [2:0] ST_WAKE    = 3'd2;
    localparam logic [2:0] ST_LOAD    = 3'd3;
    localparam logic [2:0] ST_SHIFT   = 3'd4;
    localparam logic [2:0] ST_GAP     = 3'd5;
    localparam logic [2:0] ST_READY   = 3'd6;

    // One full copy of sequencer state; three of these are kept and voted.
    typedef struct packed {
        logic [2:0]       state;
        logic [DLY_W-1:0] dly;
        logic [HC_W-1:0]  hcnt;
        logic [IDX_W-1:0] idx;
        logic [SER_W-1:0] sh;
    } seq_ctx_t;

endpackage

// File: rtl/adc_init_seq_tmr_vote.sv
// Bitwise 2-of-3 majority voter used on every triplicated register field.
module tmr_vote #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/adc_init_seq.sv
// ADC bring-up sequencer: hard reset, wake-up wait, serial configuration of
// N_WORDS words, then ADC_RDY. All state is triplicated and majority voted.
module adc_init_seq
    import adc_init_pkg::*;
#(
    parameter int RST_CYC  = 40,
    parameter int WAKE_CYC = 1000,
    parameter int SCLK_DIV = 4,
    parameter int N_WORDS  = 8
) (
    input  logic             CLK,
    input  logic             EOS,
    input  logic             ADC_INIT_RST,
    input  logic [SER_W-1:0] CFG_DATA,
    output logic             ADC_RDY,
    output logic             ADC_RST_B,
    output logic             ADC_CS_B,
    output logic             ADC_SCLK,
    output logic             ADC_SDATA,
    output logic [IDX_W-1:0] CFG_ADDR,
    output logic [2:0]       INIT_STATE
);

    localparam logic [DLY_W-1:0] RST_TC   = DLY_W'(RST_CYC - 1);
    localparam logic [DLY_W-1:0] WAKE_TC  = DLY_W'(WAKE_CYC - 1);
    localparam logic [DLY_W-1:0] HALF_TC  = DLY_W'(SCLK_DIV - 1);
    localparam logic [DLY_W-1:0] GAP_TC   = DLY_W'(2 * SCLK_DIV - 1);
    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(2 * SER_W - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    seq_ctx_t         ctx0_r, ctx1_r, ctx2_r;
    seq_ctx_t         nxt0_s, nxt1_s, nxt2_s;
    seq_ctx_t         ctx_v_s;
    logic [2:0]       vote_state_s;
    logic [DLY_W-1:0] vote_dly_s;
    logic [HC_W-1:0]  vote_hcnt_s;
    logic [IDX_W-1:0] vote_idx_s;
    logic [SER_W-1:0] vote_sh_s;

    logic rdy_nx_s, rst_b_nx_s, cs_b_nx_s, sclk_nx_s, sdata_nx_s;
    logic rdy_r, rst_b_r, cs_b_r, sclk_r, sdata_r;

    // Next context from the voted context. hcnt is the SCLK half-period index:
    // even = low half, odd = high half; the word shifts after each high half.
    function automatic seq_ctx_t next_ctx(input seq_ctx_t cur, input logic hold,
                                          input logic [SER_W-1:0] din);
        seq_ctx_t n;
        n = cur;
        if (hold) begin
            n = '0;
        end else begin
            case (cur.state)
                ST_IDLE: begin
                    n       = '0;
                    n.state = ST_HARDRST;
                end
                ST_HARDRST: begin
                    if (cur.dly == RST_TC) begin
                        n.state = ST_WAKE;
                        n.dly   = '0;
                    end else begin
                        n.dly = cur.dly + 16'd1;
                    end
                end
                ST_WAKE: begin
                    n.idx = '0;
                    if (cur.dly == WAKE_TC) begin
                        n.state = ST_LOAD;
                        n.dly   = '0;
                    end else begin
                        n.dly = cur.dly + 16'd1;
                    end
                end
                ST_LOAD: begin
                    n.sh    = din;
                    n.state = ST_SHIFT;
                    n.dly   = '0;
                    n.hcnt  = '0;
                end
                ST_SHIFT: begin
                    if (cur.dly == HALF_TC) begin
                        n.dly = '0;
                        if (cur.hcnt == HC_LAST) begin
                            n.state = ST_GAP;
                            n.hcnt  = '0;
                        end else begin
                            n.hcnt = cur.hcnt + 5'd1;
                            if (cur.hcnt[0]) begin
                                n.sh = {cur.sh[SER_W-2:0], 1'b0};
                            end else begin
                                n.sh = cur.sh;
                            end
                        end
                    end else begin
                        n.dly = cur.dly + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (cur.dly == GAP_TC) begin
                        n.dly = '0;
                        if (cur.idx == LAST_IDX) begin
                            n.state = ST_READY;
                        end else begin
                            n.idx   = cur.idx + 3'd1;
                            n.state = ST_LOAD;
                        end
                    end else begin
                        n.dly = cur.dly + 16'd1;
                    end
                end
                ST_READY: begin
                    n = cur;
                end
                default: begin
                    n = '0;
                end
            endcase
        end
        return n;
    endfunction

    tmr_vote #(.W(3))     u_vote_state (.a(ctx0_r.state), .b(ctx1_r.state), .c(ctx2_r.state), .y(vote_state_s));
    tmr_vote #(.W(DLY_W)) u_vote_dly   (.a(ctx0_r.dly),   .b(ctx1_r.dly),   .c(ctx2_r.dly),   .y(vote_dly_s));
    tmr_vote #(.W(HC_W))  u_vote_hcnt  (.a(ctx0_r.hcnt),  .b(ctx1_r.hcnt),  .c(ctx2_r.hcnt),  .y(vote_hcnt_s));
    tmr_vote #(.W(IDX_W)) u_vote_idx   (.a(ctx0_r.idx),   .b(ctx1_r.idx),   .c(ctx2_r.idx),   .y(vote_idx_s));
    tmr_vote #(.W(SER_W)) u_vote_sh    (.a(ctx0_r.sh),    .b(ctx1_r.sh),    .c(ctx2_r.sh),    .y(vote_sh_s));

    // Reassemble the voted fields into one context.
    always_comb begin
        ctx_v_s       = '0;
        ctx_v_s.state = vote_state_s;
        ctx_v_s.dly   = vote_dly_s;
        ctx_v_s.hcnt  = vote_hcnt_s;
        ctx_v_s.idx   = vote_idx_s;
        ctx_v_s.sh    = vote_sh_s;
    end

    // Next-state logic, copy 0.
    always_comb begin
        nxt0_s = next_ctx(ctx_v_s, ADC_INIT_RST, CFG_DATA);
    end

    // Next-state logic, copy 1.
    always_comb begin
        nxt1_s = next_ctx(ctx_v_s, ADC_INIT_RST, CFG_DATA);
    end

    // Next-state logic, copy 2.
    always_comb begin
        nxt2_s = next_ctx(ctx_v_s, ADC_INIT_RST, CFG_DATA);
    end

    // Triplicated context registers; a corrupted copy is rewritten from the vote.
    always_ff @(posedge CLK or negedge EOS) begin
        if (!EOS) begin
            ctx0_r <= '0;
            ctx1_r <= '0;
            ctx2_r <= '0;
        end else begin
            ctx0_r <= nxt0_s;
            ctx1_r <= nxt1_s;
            ctx2_r <= nxt2_s;
        end
    end

    // Pin levels decoded from the next context so they are valid on state entry.
    always_comb begin
        rdy_nx_s   = 1'b0;
        rst_b_nx_s = 1'b1;
        cs_b_nx_s  = 1'b1;
        sclk_nx_s  = 1'b0;
        sdata_nx_s = 1'b0;
        case (nxt0_s.state)
            ST_HARDRST: begin
                rst_b_nx_s = 1'b0;
            end
            ST_SHIFT: begin
                cs_b_nx_s  = 1'b0;
                sclk_nx_s  = nxt0_s.hcnt[0];
                sdata_nx_s = nxt0_s.sh[SER_W-1];
            end
            ST_READY: begin
                rdy_nx_s = 1'b1;
            end
            default: begin
                rdy_nx_s = 1'b0;
            end
        endcase
    end

    // Output pin registers.
    always_ff @(posedge CLK or negedge EOS) begin
        if (!EOS) begin
            rdy_r   <= 1'b0;
            rst_b_r <= 1'b1;
            cs_b_r  <= 1'b1;
            sclk_r  <= 1'b0;
            sdata_r <= 1'b0;
        end else begin
            rdy_r   <= rdy_nx_s;
            rst_b_r <= rst_b_nx_s;
            cs_b_r  <= cs_b_nx_s;
            sclk_r  <= sclk_nx_s;
            sdata_r <= sdata_nx_s;
        end
    end

    assign ADC_RDY    = rdy_r;
    assign ADC_RST_B  = rst_b_r;
    assign ADC_CS_B   = cs_b_r;
    assign ADC_SCLK   = sclk_r;
    assign ADC_SDATA  = sdata_r;
    assign CFG_ADDR   = vote_idx_s;
    assign INIT_STATE = vote_state_s;

endmodule

// File: tb/tb_adc_init_seq.sv
// Directed bench for adc_init_seq: reset, full init, restarts, SEU flips and a
// minimal-parameter instance.
module tb_adc_init_seq;
    import adc_init_pkg::*;

    localparam logic [10:0] IDLE_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0};

    logic        CLK = 1'b0;
    logic        EOS;
    logic        init_rst_a, init_rst_b;
    logic [15:0] cfg_a, cfg_b;
    logic        rdy_a, rst_b_a, cs_b_a, sclk_a, sdata_a;
    logic        rdy_b, rst_b_b, cs_b_b, sclk_b, sdata_b;
    logic [2:0]  addr_a, state_a, addr_b, state_b;
    logic        o_rdy, o_rst_b, o_cs_b, o_sclk, o_sdata;
    logic [2:0]  o_addr, o_state;
    logic [10:0] vec_a, vec_b;
    bit          sel = 1'b0;
    seq_ctx_t    seu_v;
    int          n_checks = 0;
    int          n_errors = 0;

    assign cfg_a = 16'hA500 + {13'd0, addr_a};
    assign cfg_b = 16'hA500 + {13'd0, addr_b};
    assign vec_a = {rdy_a, rst_b_a, cs_b_a, sclk_a, sdata_a, addr_a, state_a};
    assign vec_b = {rdy_b, rst_b_b, cs_b_b, sclk_b, sdata_b, addr_b, state_b};

    adc_init_seq dut (
        .CLK(CLK), .EOS(EOS), .ADC_INIT_RST(init_rst_a), .CFG_DATA(cfg_a),
        .ADC_RDY(rdy_a), .ADC_RST_B(rst_b_a), .ADC_CS_B(cs_b_a), .ADC_SCLK(sclk_a),
        .ADC_SDATA(sdata_a), .CFG_ADDR(addr_a), .INIT_STATE(state_a)
    );

    adc_init_seq #(.SCLK_DIV(1), .N_WORDS(1)) dut_e (
        .CLK(CLK), .EOS(EOS), .ADC_INIT_RST(init_rst_b), .CFG_DATA(cfg_b),
        .ADC_RDY(rdy_b), .ADC_RST_B(rst_b_b), .ADC_CS_B(cs_b_b), .ADC_SCLK(sclk_b),
        .ADC_SDATA(sdata_b), .CFG_ADDR(addr_b), .INIT_STATE(state_b)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        if (sel) begin
            {o_rdy, o_rst_b, o_cs_b, o_sclk, o_sdata, o_addr, o_state} = vec_b;
        end else begin
            {o_rdy, o_rst_b, o_cs_b, o_sclk, o_sdata, o_addr, o_state} = vec_a;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Flip one bit of one context copy for part of a cycle, between clock edges.
    task automatic seu_flip(input int cp, input bit on_sh);
        #2;
        case (cp)
            0:       seu_v = dut.ctx0_r;
            1:       seu_v = dut.ctx1_r;
            default: seu_v = dut.ctx2_r;
        endcase
        if (on_sh) seu_v.sh[15] = ~seu_v.sh[15];
        else       seu_v.state[0] = ~seu_v.state[0];
        case (cp)
            0:       force dut.ctx0_r = seu_v;
            1:       force dut.ctx1_r = seu_v;
            default: force dut.ctx2_r = seu_v;
        endcase
        #2;
        case (cp)
            0:       release dut.ctx0_r;
            1:       release dut.ctx1_r;
            default: release dut.ctx2_r;
        endcase
    endtask

    // Release the selected sequencer and check the whole bring-up it produces.
    task automatic run_seq(input bit s, input int nw, input int div, input int rdy_exp, input bit seu);
        int rst_first = -1, rst_cnt = 0, rdy_edge = -1, nfr = 0;
        int flen = 0, glen = 0, nbits = 0, viol = 0, stuck = 0;
        logic [15:0] fdata = 16'd0;
        logic p_cs = 1'b1, p_sclk = 1'b0, p_sdata = 1'b0;
        logic [15:0] fr_d[8];
        int fr_l[8], fr_g[8], fr_b[8];
        sel = s;
        if (s) init_rst_b = 1'b0;
        else   init_rst_a = 1'b0;
        for (int e = 0; e <= rdy_exp + 4; e++) begin
            @(posedge CLK); #1;
            if (!o_rst_b) begin
                if (rst_first < 0) rst_first = e;
                rst_cnt++;
            end
            if (o_rdy && rdy_edge < 0) rdy_edge = e;
            if (!o_cs_b) begin
                if (p_cs) begin
                    flen = 0; nbits = 0; fdata = 16'd0;
                    if (nfr < 8) fr_g[nfr] = glen;
                end else begin
                    if (o_sdata !== p_sdata && !(p_sclk && !o_sclk)) viol++;
                    if (o_sclk == p_sclk) stuck++;
                end
                flen++;
                if (o_sclk && !p_sclk) begin
                    fdata = {fdata[14:0], o_sdata};
                    nbits++;
                end
            end else begin
                if (!p_cs) begin
                    if (nfr < 8) begin
                        fr_d[nfr] = fdata; fr_l[nfr] = flen; fr_b[nfr] = nbits;
                    end
                    nfr++;
                    glen = 0;
                end
                glen++;
            end
            p_cs = o_cs_b; p_sclk = o_sclk; p_sdata = o_sdata;
            if (seu) begin
                case (e)
                    5:       seu_flip(0, 1'b0);
                    500:     seu_flip(1, 1'b0);
                    1040:    seu_flip(2, 1'b0);
                    1100:    seu_flip(0, 1'b0);
                    1170:    seu_flip(1, 1'b0);
                    1300:    seu_flip(2, 1'b1);
                    2137:    seu_flip(0, 1'b0);
                    default: ;
                endcase
            end
        end
        check_eq("rst_b_first_low_edge", 32'(rst_first), 32'd0);
        check_eq("rst_b_low_cycles", 32'(rst_cnt), 32'd40);
        check_eq("frame_count", 32'(nfr), 32'(nw));
        for (int k = 0; k < nw && k < 8; k++) begin
            check_eq($sformatf("frame%0d_data", k), 32'(fr_d[k]), 32'h0000A500 + 32'(k));
            check_eq($sformatf("frame%0d_len", k), 32'(fr_l[k]), 32'(32 * div));
            check_eq($sformatf("frame%0d_bits", k), 32'(fr_b[k]), 32'd16);
            if (k > 0) check_eq($sformatf("frame%0d_gap", k), 32'(fr_g[k]), 32'(2 * div + 1));
        end
        check_eq("sdata_change_outside_low_start", 32'(viol), 32'd0);
        if (div == 1) check_eq("sclk_toggle_every_cycle", 32'(stuck), 32'd0);
        check_eq("rdy_rise_edge", 32'(rdy_edge), 32'(rdy_exp));
        check_eq("final_cfg_addr", 32'(o_addr), 32'(nw - 1));
        check_eq("final_state_ready", 32'(o_state), 32'(ST_READY));
    endtask

    initial begin
        EOS = 1'b0;
        init_rst_a = 1'b1;
        init_rst_b = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("eos_reset_a", 32'(vec_a), 32'(IDLE_VEC));
        check_eq("eos_reset_b", 32'(vec_b), 32'(IDLE_VEC));
        @(negedge CLK);
        EOS = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #1;
            if (i % 25 == 24) check_eq($sformatf("hold_idle_%0d", i), 32'(vec_a), 32'(IDLE_VEC));
        end
        check_eq("hold_idle_b", 32'(vec_b), 32'(IDLE_VEC));

        // Full init with default parameters.
        run_seq(1'b0, 8, 4, 2136, 1'b0);

        // One-cycle restart pulse while Ready, then rerun with SEU flips.
        init_rst_a = 1'b1;
        @(posedge CLK); #1;
        check_eq("ready_restart_rdy", 32'(rdy_a), 32'd0);
        check_eq("ready_restart_cs_b", 32'(cs_b_a), 32'd1);
        check_eq("ready_restart_state", 32'(state_a), 32'(ST_IDLE));
        run_seq(1'b0, 8, 4, 2136, 1'b1);

        // Restart in the high half of word 3, bit 9.
        init_rst_a = 1'b1;
        @(posedge CLK); #1;
        init_rst_a = 1'b0;
        for (int e = 0; e <= 1507; e++) begin
            @(posedge CLK); #1;
        end
        check_eq("midshift_state", 32'(state_a), 32'(ST_SHIFT));
        check_eq("midshift_addr", 32'(addr_a), 32'd3);
        check_eq("midshift_sclk_high", 32'(sclk_a), 32'd1);
        init_rst_a = 1'b1;
        @(posedge CLK); #1;
        check_eq("midshift_restart_state", 32'(state_a), 32'(ST_IDLE));
        check_eq("midshift_restart_cs_b", 32'(cs_b_a), 32'd1);
        check_eq("midshift_restart_sclk", 32'(sclk_a), 32'd0);
        check_eq("midshift_restart_rdy", 32'(rdy_a), 32'd0);
        run_seq(1'b0, 8, 4, 2136, 1'b0);

        // Minimal instance: SCLK_DIV=1, N_WORDS=1.
        run_seq(1'b1, 1, 1, 1075, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_init_seq.md
# adc_init_seq

ADC bring-up sequencer on the DCFEB power-on path. It is released when the power-on-reset FSM drops `ADC_INIT_RST` in its ADC_INIT state. It then:
- hard-resets the ADCs,
- waits for wake-up,
- serially writes a block of configuration words fetched from the configuration store,
- raises `ADC_RDY`, which lets the power-on FSM enter Run_State.

State register and counters are triplicated with majority voting, matching the rest of the startup logic.

## Interface
- `RST_CYC`, 40: CLK cycles `ADC_RST_B` is held low.
- `WAKE_CYC`, 1000: CLK cycles to wait after hard reset, 16-bit counter.
- `SCLK_DIV`, 4: CLK cycles per SCLK half-period, ≥1.
- `N_WORDS`, 8: configuration words per init, 1..8.
- `CLK` in 1: system clock.
- `EOS` in 1: asynchronous active-low reset.
- `ADC_INIT_RST` in 1: synchronous level hold-off from the power-on FSM. High means sequencer idle.
- `CFG_DATA` in 16: configuration word addressed by `CFG_ADDR`. Valid one cycle after `CFG_ADDR` changes.
- `ADC_RDY` out 1: initialisation complete.
- `ADC_RST_B` out 1: ADC hard reset, active low.
- `ADC_CS_B` out 1: serial chip select, active low.
- `ADC_SCLK` out 1: serial clock.
- `ADC_SDATA` out 1: serial data, MSB first.
- `CFG_ADDR` out 3: configuration word index.
- `INIT_STATE` out 3: voted state, for debug/status readback.

## Operation
- States and encodings: Idle=0, HardRst=1, Wake=2, Load=3, Shift=4, Gap=5, Ready=6. Codes 7 and above recover to Idle on the next edge.
- All outputs are registered, decoded from next-state, so they are valid in the first cycle of each state.
- Reset (`EOS` low) puts every triplicate into Idle and forces all outputs to their reset values:

  | Output | Reset value |
  |---|---|
  | `ADC_RDY` | 0 |
  | `ADC_RST_B` | 1 |
  | `ADC_CS_B` | 1 |
  | `ADC_SCLK` | 0 |
  | `ADC_SDATA` | 0 |
  | `CFG_ADDR` | 0 |
  | `INIT_STATE` | 0 |
  | counters and word index | 0 |

- `ADC_INIT_RST` high, sampled at any edge in any state:
  - next state is Idle;
  - serial pins return to idle levels;
  - `ADC_RDY` is cleared.
  - This covers a restart mid-shift or while in Ready. `ADC_INIT_RST` has priority over every other transition.
- Idle → HardRst at the first edge with `ADC_INIT_RST` low.
- HardRst: `ADC_RST_B`=0 for exactly `RST_CYC` cycles, then → Wake.
- Wake: `ADC_RST_B`=1, word index cleared to 0, held for `WAKE_CYC` cycles, then → Load.
- Load: lasts one cycle. `CFG_DATA` for the current index is captured into a 16-bit shift register, then → Shift.
- Shift:
  - `ADC_CS_B`=0.
  - 16 bits, each 2·`SCLK_DIV` cycles: SCLK low for `SCLK_DIV` cycles, then high for `SCLK_DIV` cycles.
  - `ADC_SDATA` changes only at the start of the low half. The ADC samples on the rising SCLK edge.
  - After bit 0's high half, SCLK returns to 0 and the state moves → Gap.
- Gap:
  - `ADC_CS_B`=1 for 2·`SCLK_DIV` cycles.
  - The index increments on exit.
  - If the index was `N_WORDS`-1, → Ready; otherwise → Load.
- Ready: `ADC_RDY`=1 and is held until `ADC_INIT_RST` rises or `EOS` is asserted.
- `CFG_ADDR` always equals the voted word index. The index is stable for at least the whole Wake or Gap period before Load, which satisfies the one-cycle read latency.
- Arithmetic:
  - all counters are unsigned and compare on equality to terminal count −1;
  - the word index does not wrap and stops at `N_WORDS`-1.

## Timing
- Edge 0 is the first edge sampling `ADC_INIT_RST`=0. `ADC_RST_B` falls after edge 0 and rises after edge `RST_CYC`.
- Per word: 1 + 34·`SCLK_DIV` cycles. With defaults this is 137.
- `ADC_RDY` rises after edge `RST_CYC` + `WAKE_CYC` + `N_WORDS`·(1+34·`SCLK_DIV`). With defaults this is edge 2136.
- `ADC_INIT_RST` assertion → `ADC_RDY`=0 and `ADC_CS_B`=1 one edge later.

## Structure
- Shared package `adc_init_pkg` holds:
  - the state encoding localparams;
  - the serial word width (16);
  - the index width (3).
- One sub-module, `tmr_vote`: parameterised-width 3-input majority voter. It is used for the state, bit/half-period counter, delay counter, word index and shift register.
- The next-state logic is replicated once per triplicate, each copy driven by its own voted copy.

## Test plan
1. Reset:
   - Stimulus: `EOS` low for 5 cycles, `ADC_INIT_RST`=1 for 100 cycles.
   - Required response: all outputs stay at their reset values; `INIT_STATE`=0.
2. Full init, defaults, `CFG_DATA`=16'hA500+`CFG_ADDR`:
   - `ADC_RST_B` is low for exactly 40 cycles;
   - eight CS_B-low frames of 128 cycles each carry A500..A507 MSB-first;
   - `ADC_RDY` rises at edge 2136 and `CFG_ADDR` ends at 7.
3. Restart mid-shift: raise `ADC_INIT_RST` during word 3, bit 9 → next edge Idle, `ADC_CS_B`=1, `ADC_SCLK`=0. On release, the full sequence reruns from HardRst with word 0.
4. Restart in Ready: `ADC_INIT_RST` pulse of 1 cycle → `ADC_RDY` drops the next cycle and returns 2136 cycles after release.
5. SEU injection: flip one state-copy bit in each state, then one shift-register copy bit during Shift → sequence and serial output are unchanged.
6. Edge parameters, `SCLK_DIV`=1, `N_WORDS`=1 → SCLK toggles every cycle, one 16-bit frame, `ADC_RDY` at edge 40+1000+35=1075.
